// File: rtl/ram_gen_pkg.sv
// ram_gen_pkg -- shared types and default parameters for the ram_2p_gen family.
// Rev 1.0
`default_nettype none

package ram_gen_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int DEF_DWIDTH     = 16;
  localparam int DEF_AWIDTH     = 8;
  localparam int DEF_PIPE       = 0;
  localparam int DEF_INIT_CLEAR = 1;

endpackage

`default_nettype wire

// File: rtl/ram_2p_gen_core.sv
// ram_2p_gen_core -- storage array with one write port and one synchronous read port.
// Rev 1.0
`default_nettype none

module ram_2p_gen_core #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** AWIDTH;

  // No reset on the array or its read register so the storage maps onto block RAM.
  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/ram_2p_gen.sv
// ram_2p_gen -- single-clock two-port RAM with zero-fill sequencer, write-first
// bypass and selectable 1/2-cycle read latency. Rev 1.0
`default_nettype none

module ram_2p_gen
  import ram_gen_pkg::*;
#(
  parameter int DWIDTH     = DEF_DWIDTH,
  parameter int AWIDTH     = DEF_AWIDTH,
  parameter int PIPE       = DEF_PIPE,
  parameter int INIT_CLEAR = DEF_INIT_CLEAR
) (
  input  logic              RWCLK,
  input  logic              RESET,
  input  logic              CLR,
  input  logic              WEN,
  input  logic              REN,
  input  logic [AWIDTH-1:0] WADDR,
  input  logic [AWIDTH-1:0] RADDR,
  input  logic [DWIDTH-1:0] WD,
  output logic [DWIDTH-1:0] RD,
  output logic              RVALID,
  output logic              BUSY
);

  localparam state_e            RST_STATE = (INIT_CLEAR != 0) ? CLEAR : READY;
  localparam logic [AWIDTH-1:0] LAST_ADDR = {AWIDTH{1'b1}};

  logic [1:0]        sync_q;
  logic              rst_n;
  state_e            state_q, state_d;
  logic [AWIDTH-1:0] fill_cnt_q, fill_cnt_d;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              user_wr;
  logic              rd_issue;
  logic [DWIDTH-1:0] core_rdata;
  logic              rv1_q;
  logic              byp_q;
  logic [DWIDTH-1:0] byp_data_q;
  logic [DWIDTH-1:0] s1_data;

  // Assertion is immediate; release reaches the rest of the block two edges later.
  always_ff @(posedge RWCLK or negedge RESET) begin
    if (!RESET) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_n = sync_q[1];

  always_ff @(posedge RWCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_STATE;
      fill_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    unique case (state_q)
      CLEAR: begin
        if (CLR) begin
          fill_cnt_d = '0;
        end else if (fill_cnt_q == LAST_ADDR) begin
          state_d    = READY;
          fill_cnt_d = '0;
        end else begin
          fill_cnt_d = fill_cnt_q + 1'b1;
        end
      end
      READY: begin
        if (CLR) begin
          state_d    = CLEAR;
          fill_cnt_d = '0;
        end
      end
      default: begin
        state_d    = RST_STATE;
        fill_cnt_d = '0;
      end
    endcase
  end

  // The fill sequencer owns the write port while clearing; user traffic is dropped.
  always_comb begin
    BUSY      = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = WADDR;
    mem_wdata = WD;
    user_wr   = 1'b0;
    rd_issue  = 1'b0;
    unique case (state_q)
      CLEAR: begin
        BUSY      = 1'b1;
        mem_we    = rst_n;
        mem_waddr = fill_cnt_q;
        mem_wdata = '0;
      end
      READY: begin
        user_wr  = rst_n & WEN;
        mem_we   = rst_n & WEN;
        rd_issue = rst_n & REN;
      end
      default: begin
        BUSY = 1'b0;
      end
    endcase
  end

  ram_2p_gen_core #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_core (
    .clk_i   (RWCLK),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .re_i    (rd_issue),
    .raddr_i (RADDR),
    .rdata_o (core_rdata)
  );

  // The array returns old data on a same-address collision, so the write data is
  // captured alongside the read and substituted when the addresses matched.
  always_ff @(posedge RWCLK or negedge rst_n) begin
    if (!rst_n) begin
      rv1_q      <= 1'b0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      rv1_q <= rd_issue;
      if (rd_issue) begin
        byp_q      <= user_wr && (WADDR == RADDR);
        byp_data_q <= WD;
      end
    end
  end

  assign s1_data = byp_q ? byp_data_q : core_rdata;

  if (PIPE == 0) begin : g_pipe0
    logic [DWIDTH-1:0] hold_q;

    always_ff @(posedge RWCLK or negedge rst_n) begin
      if (!rst_n) begin
        hold_q <= '0;
      end else begin
        hold_q <= RD;
      end
    end

    assign RD     = rv1_q ? s1_data : hold_q;
    assign RVALID = rv1_q;
  end else begin : g_pipe1
    logic [DWIDTH-1:0] rd_q;
    logic              rv_q;

    always_ff @(posedge RWCLK or negedge rst_n) begin
      if (!rst_n) begin
        rd_q <= '0;
        rv_q <= 1'b0;
      end else begin
        rv_q <= rv1_q;
        if (rv1_q) begin
          rd_q <= s1_data;
        end
      end
    end

    assign RD     = rd_q;
    assign RVALID = rv_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_2p_gen.sv
// tb_ram_2p_gen -- three ram_2p_gen configurations driven side by side and
// checked against an array-level model every cycle.
`default_nettype none

module tb_ram_2p_gen;

  logic        RWCLK = 1'b0;
  logic        RESET;
  logic [2:0]  clr;
  logic        WEN, REN;
  logic [7:0]  WADDR, RADDR;
  logic [15:0] WD;
  logic [15:0] rd0, rd1;
  logic [8:0]  rd2;
  logic [2:0]  rv, busy;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 RWCLK = ~RWCLK;

  // u0: defaults; u1: PIPE=1, no auto clear; u2: 9x16, PIPE=1
  ram_2p_gen u0 (
    .RWCLK(RWCLK), .RESET(RESET), .CLR(clr[0]), .WEN(WEN), .REN(REN),
    .WADDR(WADDR), .RADDR(RADDR), .WD(WD), .RD(rd0), .RVALID(rv[0]), .BUSY(busy[0])
  );

  ram_2p_gen #(.DWIDTH(16), .AWIDTH(8), .PIPE(1), .INIT_CLEAR(0)) u1 (
    .RWCLK(RWCLK), .RESET(RESET), .CLR(clr[1]), .WEN(WEN), .REN(REN),
    .WADDR(WADDR), .RADDR(RADDR), .WD(WD), .RD(rd1), .RVALID(rv[1]), .BUSY(busy[1])
  );

  ram_2p_gen #(.DWIDTH(9), .AWIDTH(4), .PIPE(1), .INIT_CLEAR(1)) u2 (
    .RWCLK(RWCLK), .RESET(RESET), .CLR(clr[2]), .WEN(WEN), .REN(REN),
    .WADDR(WADDR[3:0]), .RADDR(RADDR[3:0]), .WD(WD[8:0]), .RD(rd2), .RVALID(rv[2]), .BUSY(busy[2])
  );

  function automatic int dep(input int k);
    return (k == 2) ? 16 : 256;
  endfunction
  function automatic int lat(input int k);
    return (k == 0) ? 1 : 2;
  endfunction
  function automatic bit ic(input int k);
    return (k == 1) ? 1'b0 : 1'b1;
  endfunction
  function automatic logic [7:0] am(input int k);
    return (k == 2) ? 8'h0F : 8'hFF;
  endfunction
  function automatic logic [15:0] dm(input int k);
    return (k == 2) ? 16'h01FF : 16'hFFFF;
  endfunction

  // Model: a fill is "busy for DEPTH active cycles, then the array is all zero";
  // reads are a delay line of the array value (after any same-cycle write).
  int          rel    [3];
  bit          m_busy [3];
  int          m_left [3];
  logic [15:0] m_mem  [3][256];
  bit          m_rv   [3];
  logic [15:0] m_rd   [3];
  bit          pv     [3][2];
  logic [15:0] pd     [3][2];

  always @(posedge RWCLK or negedge RESET) begin
    bit          nv;
    logic [15:0] nd;
    for (int k = 0; k < 3; k++) begin
      if (!RESET) begin
        rel[k]    = 0;
        m_busy[k] = ic(k);
        m_left[k] = dep(k);
        m_rv[k]   = 1'b0;
        m_rd[k]   = 16'h0;
        pv[k][0]  = 1'b0;
        pv[k][1]  = 1'b0;
      end else if (rel[k] < 2) begin
        rel[k]++;
      end else begin
        nv = 1'b0;
        nd = 16'h0;
        if (m_busy[k]) begin
          if (clr[k]) begin
            m_left[k] = dep(k);
          end else begin
            m_left[k]--;
            if (m_left[k] == 0) begin
              m_busy[k] = 1'b0;
              for (int a = 0; a < dep(k); a++) m_mem[k][a] = 16'h0;
            end
          end
        end else begin
          if (WEN) m_mem[k][WADDR & am(k)] = WD & dm(k);
          if (REN) begin
            nv = 1'b1;
            nd = m_mem[k][RADDR & am(k)];
          end
          if (clr[k]) begin
            m_busy[k] = 1'b1;
            m_left[k] = dep(k);
          end
        end
        pv[k][1] = pv[k][0];
        pd[k][1] = pd[k][0];
        pv[k][0] = nv;
        pd[k][0] = nd;
        m_rv[k]  = pv[k][lat(k)-1];
        if (m_rv[k]) m_rd[k] = pd[k][lat(k)-1];
      end
    end
  end

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge RWCLK) begin
    if (chk_en) begin
      check("u0 BUSY",   16'(busy[0]), 16'(m_busy[0]));
      check("u1 BUSY",   16'(busy[1]), 16'(m_busy[1]));
      check("u2 BUSY",   16'(busy[2]), 16'(m_busy[2]));
      check("u0 RVALID", 16'(rv[0]),   16'(m_rv[0]));
      check("u1 RVALID", 16'(rv[1]),   16'(m_rv[1]));
      check("u2 RVALID", 16'(rv[2]),   16'(m_rv[2]));
      check("u0 RD",     rd0,          m_rd[0]);
      check("u1 RD",     rd1,          m_rd[1]);
      check("u2 RD",     16'(rd2),     m_rd[2]);
    end
  end

  // Call #1 after an edge; counts consecutive BUSY samples, one per cycle.
  task automatic count_busy(input int k, output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      if (!busy[k]) break;
      n++;
      @(posedge RWCLK);
      #1;
    end
  endtask

  task automatic read_chk(input logic [7:0] a, input logic [15:0] e0, input logic [15:0] e1);
    @(negedge RWCLK);
    REN = 1'b1;
    RADDR = a;
    @(posedge RWCLK);
    #1;
    check("u0 read data", rd0, e0);
    check("u0 read valid", 16'(rv[0]), 16'd1);
    check("u1 valid before latency", 16'(rv[1]), 16'd0);
    @(negedge RWCLK);
    REN = 1'b0;
    @(posedge RWCLK);
    #1;
    check("u1 read data", rd1, e1);
    check("u1 read valid", 16'(rv[1]), 16'd1);
    check("u0 valid one-shot", 16'(rv[0]), 16'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n2;
    RESET = 1'b0;
    clr   = 3'b000;
    WEN   = 1'b0;
    REN   = 1'b0;
    WADDR = 8'h00;
    RADDR = 8'h00;
    WD    = 16'h0;
    chk_en = 1'b1;

    @(posedge RWCLK);
    #1;
    check("reset u0 RD", rd0, 16'h0);
    check("reset u0 RVALID", 16'(rv[0]), 16'd0);
    check("reset u0 BUSY", 16'(busy[0]), 16'd1);
    check("reset u1 BUSY", 16'(busy[1]), 16'd0);

    // Release; while u0 fills, load every u1 address (u0 must drop these writes).
    repeat (2) @(negedge RWCLK);
    RESET = 1'b1;
    @(posedge RWCLK);
    @(posedge RWCLK);
    n0 = 0;
    n2 = 0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (busy[0]) n0++;
      if (busy[2]) n2++;
      @(negedge RWCLK);
      if (i < 256) begin
        WEN   = 1'b1;
        WADDR = 8'(i);
        WD    = (i == 5) ? 16'hBEEF : (16'(i * 257) ^ 16'h3C3C);
      end else begin
        WEN = 1'b0;
      end
      @(posedge RWCLK);
    end
    check("initial fill cycles u0", 16'(n0), 16'd256);
    check("initial fill cycles u2", 16'(n2), 16'd16);

    read_chk(8'h00, 16'h0000, 16'h3C3C);
    read_chk(8'hFF, 16'h0000, 16'hC3C3);
    read_chk(8'h05, 16'h0000, 16'hBEEF);

    @(negedge RWCLK);
    WEN = 1'b1; WADDR = 8'h10; WD = 16'hA5A5;
    @(negedge RWCLK);
    WEN = 1'b0;
    read_chk(8'h10, 16'hA5A5, 16'hA5A5);

    // Same-address write and read in one cycle returns the new data.
    @(negedge RWCLK);
    WEN = 1'b1; WADDR = 8'h20; WD = 16'hFFFF;
    @(negedge RWCLK);
    WD = 16'h1234; REN = 1'b1; RADDR = 8'h20;
    @(posedge RWCLK);
    #1;
    check("bypass u0", rd0, 16'h1234);
    @(negedge RWCLK);
    WEN = 1'b0; REN = 1'b0;
    @(posedge RWCLK);
    #1;
    check("bypass u1", rd1, 16'h1234);

    // CLR mid-fill restarts a full DEPTH-cycle fill from its edge.
    @(negedge RWCLK);
    clr[0] = 1'b1;
    @(negedge RWCLK);
    clr[0] = 1'b0;
    repeat (50) @(negedge RWCLK);
    clr[0] = 1'b1;
    @(posedge RWCLK);
    #1;
    clr[0] = 1'b0;
    count_busy(0, n0);
    check("CLR restart cycles", 16'(n0), 16'd256);

    // Reset while u0 is at fill address 100 and a u1 read is in flight.
    @(negedge RWCLK);
    clr[0] = 1'b1;
    @(posedge RWCLK);
    #1;
    clr[0] = 1'b0;
    repeat (99) @(posedge RWCLK);
    @(negedge RWCLK);
    REN = 1'b1; RADDR = 8'h05;
    @(posedge RWCLK);
    #2;
    RESET = 1'b0;
    REN = 1'b0;
    #1;
    check("async reset u0 RD", rd0, 16'h0);
    check("async reset u0 RVALID", 16'(rv[0]), 16'd0);
    check("async reset u1 RD", rd1, 16'h0);
    check("async reset u1 RVALID", 16'(rv[1]), 16'd0);
    repeat (2) @(negedge RWCLK);
    RESET = 1'b1;
    @(posedge RWCLK);
    @(posedge RWCLK);
    #1;
    count_busy(0, n0);
    check("refill after reset cycles", 16'(n0), 16'd256);
    read_chk(8'h05, 16'h0000, 16'hBEEF);
    read_chk(8'h10, 16'h0000, 16'hA5A5);

    // Stream: each address 0..15 holds its own value.
    for (int i = 0; i < 16; i++) begin
      @(negedge RWCLK);
      WEN = 1'b1; WADDR = 8'(i); WD = 16'(i);
    end
    @(negedge RWCLK);
    WEN = 1'b0;
    for (int c = 0; c < 18; c++) begin
      @(negedge RWCLK);
      REN   = (c < 16);
      RADDR = 8'(c);
      @(posedge RWCLK);
      #1;
      if (c >= 1 && c <= 16) begin
        check("u2 stream data", 16'(rd2), 16'(c - 1));
        check("u2 stream valid", 16'(rv[2]), 16'd1);
      end
    end

    @(negedge RWCLK);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
